// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//
// MEM-stage consumer of the EX/ST-to-MEM pipeline register.  Non-memory
// instructions retire one cycle after they are sampled.  Loads and stores
// are issued to a variable-latency data memory over a req/ack handshake.
// The upstream register is held (EXSTtoMEM_Wen=0) until the access
// completes or times out.
//
// Ports:
//   clk, resetn        rising-edge clock, asynchronous active-low reset
//   valid_in           pipeline register holds a live instruction
//   mem_addr_in        access address
//   rdest_addr_in      destination register
//   data_in            store data / ALU result
//   load_in, store_in  memory-op kind (both set => store)
//   PC_wr_in           PC-write flag, forwarded unchanged
//   EXSTtoMEM_Wen      upstream register may load the next instruction
//   dmem_req/we/addr/wdata   data-memory request side
//   dmem_ack/rdata     data-memory completion pulse and read data
//   wb_valid           one-cycle pulse per retired instruction
//   wb_reg_we          writeback must write wb_rdest_addr
//   wb_rdest_addr      destination register
//   wb_data            writeback data
//   wb_PC_wr           forwarded PC_wr
//   mem_err            sticky timeout flag
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [2:0]        rdest_addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_in,
    input  logic              store_in,
    input  logic              PC_wr_in,
    output logic              EXSTtoMEM_Wen,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_we,
    output logic [2:0]        wb_rdest_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_PC_wr,
    output logic              mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             cap_load;
    logic [2:0]       cap_rdest;
    logic             cap_pc_wr;

    logic             mem_op;
    logic             timeout_hit;

    // Classify the incoming instruction and decide whether the upstream
    // register may advance.  While waiting, only the cycle that ends the
    // access (ack or timeout) releases the stall, so the next instruction
    // is presented exactly when we return to IDLE.
    always_comb begin
        mem_op        = valid_in & (load_in | store_in);
        timeout_hit   = (state == S_WAIT) && !dmem_ack && (wait_cnt == CNT_LAST);
        EXSTtoMEM_Wen = 1'b0;
        if (state == S_IDLE) begin
            EXSTtoMEM_Wen = ~mem_op;
        end else begin
            EXSTtoMEM_Wen = dmem_ack | timeout_hit;
        end
    end

    // Main controller.  Everything the access needs (kind, destination,
    // PC_wr) is captured at issue so upstream changes during WAIT are
    // harmless.  A load+store combination is issued as a store.  An ack
    // in the timeout cycle takes priority, leaving mem_err untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            cap_load      <= 1'b0;
            cap_rdest     <= '0;
            cap_pc_wr     <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_reg_we     <= 1'b0;
            wb_rdest_addr <= '0;
            wb_data       <= '0;
            wb_PC_wr      <= 1'b0;
            mem_err       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        dmem_addr  <= mem_addr_in;
                        dmem_wdata <= data_in;
                        dmem_we    <= store_in;
                        dmem_req   <= 1'b1;
                        cap_load   <= load_in & ~store_in;
                        cap_rdest  <= rdest_addr_in;
                        cap_pc_wr  <= PC_wr_in;
                        wait_cnt   <= '0;
                        state      <= S_WAIT;
                    end else if (valid_in) begin
                        wb_valid      <= 1'b1;
                        wb_reg_we     <= 1'b1;
                        wb_data       <= data_in;
                        wb_rdest_addr <= rdest_addr_in;
                        wb_PC_wr      <= PC_wr_in;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack || timeout_hit) begin
                        dmem_req      <= 1'b0;
                        state         <= S_IDLE;
                        wb_valid      <= 1'b1;
                        wb_rdest_addr <= cap_rdest;
                        wb_PC_wr      <= cap_pc_wr;
                        if (dmem_ack && cap_load) begin
                            wb_reg_we <= 1'b1;
                            wb_data   <= dmem_rdata;
                        end else begin
                            wb_reg_we <= 1'b0;
                            wb_data   <= '0;
                        end
                        if (timeout_hit) begin
                            mem_err <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
